// File: rtl/dct_dispatcher.sv
// DCT scheduling controller: detects ingester bank swaps and walks every MCU group/round
// of the completed bank across the engine pool. Optional macro: DCT_DISPATCH_RECOVER_EN.

module dct_dispatch_lane #(
  parameter int NUM_BLOCKS  = 5,
  parameter int NUM_ENGINES = 5,
  parameter int LANE        = 0,
  parameter int RND_W       = 1,
  parameter int BLK_W       = 1
) (
  input  logic [RND_W-1:0] round,
  output logic             valid,
  output logic [BLK_W-1:0] sel
);
  logic [31:0] idx;

  assign idx   = 32'(round) * 32'(NUM_ENGINES) + 32'(LANE);
  assign valid = idx < 32'(NUM_BLOCKS);
  assign sel   = valid ? idx[BLK_W-1:0] : '0;
endmodule

module dct_dispatcher #(
  parameter int NUM_BLOCKS   = 5,
  parameter int NUM_ENGINES  = 5,
  parameter int MCU_GROUPS   = 8,
  parameter int RESET_CYCLES = 3,
  localparam int ROUNDS = (NUM_BLOCKS + NUM_ENGINES - 1) / NUM_ENGINES,
  localparam int BLK_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
  localparam int RND_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
  localparam int GRP_W  = (MCU_GROUPS > 1) ? $clog2(MCU_GROUPS) : 1,
  localparam int HC_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1,
  localparam int ADDR_W = $clog2(MCU_GROUPS) + 6
) (
  input  logic                         clock,
  input  logic                         nreset,
  input  logic                         frontbuffer_select,
  input  logic [NUM_ENGINES-1:0]       engines_finished,
  output logic                         engine_run,
  output logic                         read_bank,
  output logic [RND_W-1:0]             round,
  output logic [NUM_ENGINES*BLK_W-1:0] engine_block_sel,
  output logic [NUM_ENGINES-1:0]       engine_valid,
  output logic [ADDR_W-1:0]            fetch_base,
  output logic [1:0]                   result_bank,
  output logic                         frame_done,
  output logic                         overrun,
  output logic                         busy
);
  typedef enum logic [1:0] {IDLE, HOLD, ACTIVE, ERR} state_t;

  state_t                              state, state_nxt;
  logic                                s0, s1, swap;
  logic [GRP_W-1:0]                    group, group_nxt;
  logic [RND_W-1:0]                    round_nxt;
  logic [HC_W-1:0]                     hold_cnt, hold_cnt_nxt;
  logic [NUM_ENGINES-1:0]              done_latch, done_latch_nxt;
  logic [1:0]                          result_bank_nxt;
  logic                                read_bank_nxt, frame_done_nxt, overrun_nxt;
  logic                                pass_done, last_round, last_group, ovr;
  logic [NUM_ENGINES-1:0][BLK_W-1:0]   sel_lane;

  // per-engine block mapping decoded from the registered round only
  for (genvar e = 0; e < NUM_ENGINES; e++) begin : g_lane
    dct_dispatch_lane #(
      .NUM_BLOCKS(NUM_BLOCKS), .NUM_ENGINES(NUM_ENGINES), .LANE(e),
      .RND_W(RND_W), .BLK_W(BLK_W)
    ) u_lane (
      .round(round), .valid(engine_valid[e]), .sel(sel_lane[e])
    );
  end

  assign engine_block_sel = sel_lane;
  assign fetch_base       = ADDR_W'(group) << 6;
  assign engine_run       = (state == ACTIVE);
  assign busy             = (state != IDLE);

  assign swap       = (s0 != s1);
  assign last_round = (round == RND_W'(ROUNDS - 1));
  assign last_group = (group == GRP_W'(MCU_GROUPS - 1));
  // invalid lanes count as done so a partial last round can complete
  assign pass_done  = &(done_latch | engines_finished | ~engine_valid);
  assign ovr        = swap && (state == HOLD || state == ACTIVE);

  always_ff @(posedge clock) begin
    if (nreset) begin
      state       <= IDLE;
      s0          <= 1'b0;
      s1          <= 1'b0;
      read_bank   <= 1'b0;
      round       <= '0;
      group       <= '0;
      hold_cnt    <= '0;
      done_latch  <= '0;
      result_bank <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      s0          <= frontbuffer_select;
      s1          <= s0;
      read_bank   <= read_bank_nxt;
      round       <= round_nxt;
      group       <= group_nxt;
      hold_cnt    <= hold_cnt_nxt;
      done_latch  <= done_latch_nxt;
      result_bank <= result_bank_nxt;
      frame_done  <= frame_done_nxt;
      overrun     <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    read_bank_nxt   = read_bank;
    round_nxt       = round;
    group_nxt       = group;
    hold_cnt_nxt    = hold_cnt;
    done_latch_nxt  = done_latch;
    result_bank_nxt = result_bank;
    frame_done_nxt  = 1'b0;
    overrun_nxt     = overrun;

    case (state)
      IDLE: begin
        round_nxt = '0;
        group_nxt = '0;
        if (swap) begin
          read_bank_nxt  = s1;
          hold_cnt_nxt   = '0;
          done_latch_nxt = '0;
          state_nxt      = HOLD;
        end
      end
      HOLD: begin
        if (!ovr) begin
          done_latch_nxt = '0;
          if (hold_cnt == HC_W'(RESET_CYCLES - 1)) state_nxt = ACTIVE;
          else hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      ACTIVE: begin
        if (!ovr) begin
          if (pass_done) begin
            result_bank_nxt = result_bank + 2'd1;
            hold_cnt_nxt    = '0;
            done_latch_nxt  = '0;
            if (!last_round) begin
              round_nxt = round + 1'b1;
              state_nxt = HOLD;
            end else if (!last_group) begin
              round_nxt = '0;
              group_nxt = group + 1'b1;
              state_nxt = HOLD;
            end else begin
              round_nxt      = '0;
              group_nxt      = '0;
              frame_done_nxt = 1'b1;
              state_nxt      = IDLE;
            end
          end else begin
            done_latch_nxt = done_latch | (engines_finished & engine_valid);
          end
        end
      end
      default: ;
    endcase

    // a swap mid-dispatch wins over any same-cycle pass completion
    if (ovr) begin
      overrun_nxt = 1'b1;
`ifdef DCT_DISPATCH_RECOVER_EN
      read_bank_nxt  = s1;
      group_nxt      = '0;
      round_nxt      = '0;
      hold_cnt_nxt   = '0;
      done_latch_nxt = '0;
      state_nxt      = HOLD;
`else
      state_nxt      = ERR;
`endif
    end
  end
endmodule

// File: tb/tb_dct_dispatcher.sv
// Directed bench for dct_dispatcher: default 5x5 instance plus a 5-block/3-engine instance.
module tb_dct_dispatcher;
  logic        clock = 1'b0;
  logic        nreset;
  logic        fb, fb3;
  logic [4:0]  fin;
  logic [2:0]  fin3;
  logic        run, rbank, fdone, ovr, busy;
  logic [0:0]  rnd;
  logic [14:0] sel;
  logic [4:0]  vld;
  logic [8:0]  fbase;
  logic [1:0]  rb;
  logic        run3, rbank3, fdone3, ovr3, busy3;
  logic [0:0]  rnd3;
  logic [8:0]  sel3;
  logic [2:0]  vld3;
  logic [8:0]  fbase3;
  logic [1:0]  rb3;
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  dct_dispatcher dut (
    .clock(clock), .nreset(nreset), .frontbuffer_select(fb), .engines_finished(fin),
    .engine_run(run), .read_bank(rbank), .round(rnd), .engine_block_sel(sel),
    .engine_valid(vld), .fetch_base(fbase), .result_bank(rb), .frame_done(fdone),
    .overrun(ovr), .busy(busy)
  );

  dct_dispatcher #(.NUM_ENGINES(3)) dut3 (
    .clock(clock), .nreset(nreset), .frontbuffer_select(fb3), .engines_finished(fin3),
    .engine_run(run3), .read_bank(rbank3), .round(rnd3), .engine_block_sel(sel3),
    .engine_valid(vld3), .fetch_base(fbase3), .result_bank(rb3), .frame_done(fdone3),
    .overrun(ovr3), .busy(busy3)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // steps until engine_run rises; exp is the number of edges it should take
  task automatic wait_run(input bit which, input int exp, input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (((which ? run3 : run) !== 1'b1) && n < 100);
    chk(tag, n, exp);
  endtask

  // one full pass on the default instance with all engines finishing together
  task automatic pass_all(input int g, input int rb_exp);
    chk("pass_fetch", fbase, g * 64);
    chk("pass_rb", rb, rb_exp);
    chk("pass_run", run, 1);
    fin = 5'h1f;
    step();
    fin = 5'h00;
    chk("pass_run_off", run, 0);
    chk("pass_rb_next", rb, (rb_exp + 1) % 4);
    if (g < 7) begin
      chk("pass_fetch_next", fbase, (g + 1) * 64);
      wait_run(0, 3, "pass_gap");
    end else begin
      chk("frame_done_hi", fdone, 1);
      chk("frame_idle", busy, 0);
      chk("frame_fetch0", fbase, 0);
      step();
      chk("frame_done_lo", fdone, 0);
    end
  endtask

  initial begin
    nreset = 1'b1; fb = 1'b0; fb3 = 1'b0; fin = '0; fin3 = '0;
    step(); step();
    chk("rst_run", run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rbank", rbank, 0);
    chk("rst_round", rnd, 0);
    chk("rst_fetch", fbase, 0);
    chk("rst_rb", rb, 0);
    chk("rst_fdone", fdone, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_vld", vld, 5'h1f);
    chk("rst_sel", sel, 15'h4688);
    nreset = 1'b0;
    step();

    // frame 1: bank 0 completes, eight groups
    fb = 1'b1;
    step();
    chk("swap_idle", busy, 0);
    step();
    chk("hold_busy", busy, 1);
    chk("hold_run", run, 0);
    chk("hold_rbank", rbank, 0);
    wait_run(0, 3, "first_run");
    for (int g = 0; g < 8; g++) pass_all(g, g % 4);
    chk("f1_ovr", ovr, 0);

    // frame 2: bank 1, staggered finishes in group 0
    fb = 1'b0;
    wait_run(0, 5, "f2_run");
    chk("f2_rbank", rbank, 1);
    for (int c = 1; c <= 40; c++) begin
      fin = (c == 10) ? 5'b00001 : (c == 20) ? 5'b01110 : (c == 40) ? 5'b10000 : 5'b00000;
      step();
      if (c == 39) chk("stagger_hold", run, 1);
    end
    fin = '0;
    chk("stagger_off", run, 0);
    chk("stagger_fetch", fbase, 64);
    wait_run(0, 3, "stagger_gap");
    pass_all(1, 1);
    pass_all(2, 2);

    // swap while group 3 is active
    chk("g3_fetch", fbase, 192);
    fb = 1'b1;
    step();
    chk("ovr_pre_run", run, 1);
    chk("ovr_pre", ovr, 0);
    step();
    chk("ovr_set", ovr, 1);
    chk("ovr_run", run, 0);
    chk("ovr_busy", busy, 1);
`ifdef DCT_DISPATCH_RECOVER_EN
    chk("rec_rbank", rbank, 0);
    chk("rec_fetch", fbase, 0);
    chk("rec_rb", rb, 3);
    wait_run(0, 3, "rec_hold");
    for (int g = 0; g < 8; g++) pass_all(g, (3 + g) % 4);
    chk("rec_ovr_sticky", ovr, 1);
`else
    fin = 5'h1f;
    step(); step(); step(); step();
    fin = '0;
    chk("err_run", run, 0);
    chk("err_busy", busy, 1);
    chk("err_fetch", fbase, 192);
    chk("err_rb", rb, 3);
    chk("err_ovr", ovr, 1);
`endif

    // reset clears overrun and any frozen state
    nreset = 1'b1; fb = 1'b0;
    step();
    chk("rst2_busy", busy, 0);
    chk("rst2_ovr", ovr, 0);
    chk("rst2_rb", rb, 0);
    chk("rst2_fetch", fbase, 0);
    nreset = 1'b0;
    step();

    // frame 3: reset asserted during group 5
    fb = 1'b1;
    wait_run(0, 5, "f3_run");
    for (int g = 0; g < 5; g++) pass_all(g, g % 4);
    chk("g5_fetch", fbase, 320);
    nreset = 1'b1; fb = 1'b0;
    step();
    chk("abort_run", run, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fetch", fbase, 0);
    chk("abort_rb", rb, 0);
    chk("abort_round", rnd, 0);
    chk("abort_rbank", rbank, 0);
    chk("abort_fdone", fdone, 0);
    chk("abort_ovr", ovr, 0);
    nreset = 1'b0;
    step(); step(); step(); step();
    chk("abort_stay_idle", busy, 0);
    fb = 1'b1;
    wait_run(0, 5, "restart_run");
    chk("restart_fetch", fbase, 0);
    chk("restart_round", rnd, 0);

    // 5 blocks on 3 engines: two rounds per group
    fb3 = 1'b1;
    wait_run(1, 5, "d3_run");
    chk("d3_r0_round", rnd3, 0);
    chk("d3_r0_vld", vld3, 3'b111);
    chk("d3_r0_sel", sel3, 9'h088);
    fin3 = 3'b111;
    step();
    fin3 = '0;
    chk("d3_r0_off", run3, 0);
    chk("d3_r1_round", rnd3, 1);
    wait_run(1, 3, "d3_r1_gap");
    chk("d3_r1_vld", vld3, 3'b011);
    chk("d3_r1_sel", sel3, 9'h023);
    chk("d3_r1_fetch", fbase3, 0);
    fin3 = 3'b100;
    step();
    chk("d3_invalid_ignored", run3, 1);
    fin3 = 3'b001;
    step();
    chk("d3_partial", run3, 1);
    fin3 = 3'b010;
    step();
    fin3 = '0;
    chk("d3_r1_done", run3, 0);
    chk("d3_g1_round", rnd3, 0);
    chk("d3_g1_fetch", fbase3, 64);
    chk("d3_g1_rb", rb3, 2);
    for (int i = 0; i < 14; i++) begin
      wait_run(1, 3, "d3_gap");
      fin3 = 3'b111;
      step();
      fin3 = '0;
      chk("d3_frame_done", fdone3, (i == 13) ? 1 : 0);
    end
    chk("d3_end_rb", rb3, 0);
    chk("d3_end_busy", busy3, 0);
    chk("d3_end_ovr", ovr3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dct_dispatcher.md
# dct_dispatcher

Parametrised DCT scheduling controller for the jpeg compressor datapath, sitting between the hm01b0 ingester's double-buffered EBR banks and a pool of loeffler DCT engines. It detects ingester bank swaps and holds the engines in reset for a fixed window. It then walks every MCU group of the completed bank, mapping NUM_BLOCKS input EBRs onto NUM_ENGINES engines over as many rounds as needed. A pass ends only when all active engines have finished. It also reports frame completion and bank overrun.

## Interface
- NUM_BLOCKS, 5: input EBRs per bank (one 8-pixel-row MCU slice each).
- NUM_ENGINES, 5: DCT engines driven; ROUNDS = ceil(NUM_BLOCKS/NUM_ENGINES).
- MCU_GROUPS, 8: 64-sample MCU groups per EBR per bank.
- RESET_CYCLES, 3: cycles engines are held in reset before each pass (>=1).
- BLK_W = max(1,clog2(NUM_BLOCKS)); ADDR_W = clog2(MCU_GROUPS)+6 (derived, localparam).

Ports:
- clock  in  1  system clock.
- nreset  in  1  reset, synchronous, active-high.
- frontbuffer_select  in  1  bank the ingester is currently writing.
- engines_finished  in  NUM_ENGINES  per-engine finished, sampled every cycle.
- engine_run  out  1  1 = engines released; 0 = engines held in reset.
- read_bank  out  1  bank the engines read (the bank just filled).
- round  out  max(1,clog2(ROUNDS))  current round within the MCU group.
- engine_block_sel  out  NUM_ENGINES*BLK_W  engine e reads block round*NUM_ENGINES+e (slice e).
- engine_valid  out  NUM_ENGINES  engine e maps to an existing block this round.
- fetch_base  out  ADDR_W  group*64, added to engine fetch address.
- result_bank  out  2  output-buffer quadrant for the current pass.
- frame_done  out  1  one-cycle pulse after the last pass of a bank.
- overrun  out  1  sticky: ingester swapped banks before the dispatch finished.
- busy  out  1  state != IDLE.

## Operation
- Swap detect: s0<=frontbuffer_select, s1<=s0; swap = (s0!=s1).
- States: IDLE, HOLD, ACTIVE, ERR. engine_run=1 only in ACTIVE.
- IDLE: group=0, round=0. On swap: read_bank<=s1 (the bank just completed), hold_cnt<=0, go to HOLD.
- HOLD: hold_cnt counts up. When hold_cnt==RESET_CYCLES-1, go to ACTIVE. Clear the done-latch on entry.
- ACTIVE: done_latch |= engines_finished & engine_valid. The pass completes when (done_latch | engines_finished) covers every engine_valid bit. Invalid engines are ignored.
- Pass complete: result_bank += 1 (wraps mod 4).
  - If round<ROUNDS-1: round+1, go to HOLD.
  - Else, if group<MCU_GROUPS-1: round=0, group+1, go to HOLD.
  - Else: round=0, group=0, frame_done=1 for one cycle, go to IDLE.
- engine_valid[e] = (round*NUM_ENGINES+e < NUM_BLOCKS). engine_block_sel lanes for invalid engines drive 0.
- Swap while in HOLD or ACTIVE sets overrun=1 and is handled per Configuration. A swap in the same cycle as pass completion counts as an overrun and takes priority.
- overrun is cleared only by nreset.
- ERR: engine_run=0, all counters frozen, exits only on nreset.

## Timing
- All state is registered. engine_run, engine_valid, engine_block_sel and fetch_base decode from registers with no input-to-output combinational path.
- frontbuffer_select toggles at edge N. swap is high after edge N+1. State is HOLD after edge N+2, and engine_run rises after edge N+2+RESET_CYCLES.
- Last finished at edge F: engine_run is 0 after F+1, and round/group/result_bank update at F+1.
- Consecutive passes are separated by exactly RESET_CYCLES cycles of engine_run=0.
- nreset reset values (all outputs/registers): state IDLE, s0=s1=0, read_bank 0, round 0, group 0, result_bank 0, hold_cnt 0, done_latch 0, frame_done 0, overrun 0, engine_run 0, busy 0.
- nreset mid-pass aborts the pass immediately. The next bank is only processed after its next swap.

## Configuration
- DCT_DISPATCH_RECOVER_EN defined: a swap in HOLD/ACTIVE sets overrun, abandons the current bank, sets read_bank<=s1, resets group/round/hold_cnt to 0, clears done_latch and re-enters HOLD. result_bank keeps counting. ERR is unreachable.
- Undefined: a swap in HOLD/ACTIVE sets overrun and enters ERR until nreset.

## Test plan
- Defaults, toggle frontbuffer_select 0->1, pulse all finished per pass -> read_bank=0; 8 passes with fetch_base 0,64,...,448; result_bank ends at 0; one frame_done; overrun=0.
- NUM_BLOCKS=5, NUM_ENGINES=3 -> round 0: engine_valid=3'b111, sel 0,1,2; round 1: engine_valid=3'b011, sel 3,4,0; finishes from engines 0,1 only complete round 1; 16 passes total.
- Staggered finished (engine 0 at cycle 10, engine 4 at cycle 40) -> engine_run stays 1 until the cycle after engine 4 finishes; gap to next engine_run is exactly 3 cycles.
- Second toggle during group 3 ACTIVE, macro undefined -> overrun=1, state ERR, engine_run=0 held until nreset.
- Same stimulus with DCT_DISPATCH_RECOVER_EN -> overrun=1, read_bank flips, fetch_base=0, HOLD for 3 cycles, then a full 8-group frame with frame_done.
- nreset asserted in ACTIVE group 5 -> next cycle all outputs at reset values; a fresh toggle restarts at group 0.
